// File: rtl/key_note_ctrl.sv
// Two-key note controller: synchronized and debounced buttons drive a gate
// output and step through an eight-entry note-frequency table.
module key_note_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned FREQ_WIDTH      = 32,
    parameter int unsigned FREQ_FRAC_BITS  = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [1:0]            key_n,
    output logic                  gate,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic [2:0]            note_idx,
    output logic                  note_strobe,
    output logic                  retrig
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned NOTE_HZ [8] = '{440, 494, 523, 587, 659, 698, 784, 880};
    localparam logic [FREQ_WIDTH-1:0] FREQ_RST = FREQ_WIDTH'(NOTE_HZ[0]) << FREQ_FRAC_BITS;

    if (DEBOUNCE_CYCLES < 1) begin : g_deb_err
        $error("key_note_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end

    for (genvar g = 0; g < 8; g++) begin : g_table_chk
        if (FREQ_FRAC_BITS + $clog2(NOTE_HZ[g] + 1) > FREQ_WIDTH) begin : g_range_err
            $error("key_note_ctrl: note table entry %0d does not fit in FREQ_WIDTH", g);
        end
    end

    function automatic logic [FREQ_WIDTH-1:0] note_freq(input logic [2:0] idx);
        return FREQ_WIDTH'(NOTE_HZ[idx]) << FREQ_FRAC_BITS;
    endfunction

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [CNT_W-1:0] r_cnt [2];
    logic             r_gate;
    logic [2:0]       r_note_idx;
    logic             r_adv;
    logic [FREQ_WIDTH-1:0] r_freq;
    logic             r_strobe;
    logic             r_retrig;

    logic [1:0]       w_accept;
    logic             w_press;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // A key's new level is accepted on the edge its mismatch counter is already at the last count.
    always_comb begin
        w_accept = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            w_accept[k] = (r_sync2[k] != r_deb[k]) && (r_cnt[k] == CNT_LAST);
        end
    end

    assign w_press = w_accept[1] & ~r_sync2[1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_deb <= '1;
            for (int unsigned k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_gate     <= 1'b0;
            r_note_idx <= '0;
            r_adv      <= 1'b0;
        end else begin
            if (w_accept[0]) begin
                r_gate <= ~r_sync2[0];
            end
            if (w_press) begin
                r_note_idx <= r_note_idx + 3'd1;
            end
            r_adv <= w_press;
        end
    end

    // Frequency follows the index one cycle later, so retrig sees any gate change from the same press edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_freq   <= FREQ_RST;
            r_strobe <= 1'b0;
            r_retrig <= 1'b0;
        end else begin
            r_strobe <= r_adv;
            r_retrig <= r_adv & r_gate;
            if (r_adv) begin
                r_freq <= note_freq(r_note_idx);
            end
        end
    end

    assign gate        = r_gate;
    assign freq        = r_freq;
    assign note_idx    = r_note_idx;
    assign note_strobe = r_strobe;
    assign retrig      = r_retrig;

endmodule

// File: tb/tb_key_note_ctrl.sv
// Directed bench for key_note_ctrl with a 16-cycle debounce and 16.16 frequency format.
module tb_key_note_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  key_n;
    logic        gate;
    logic [31:0] freq;
    logic [2:0]  note_idx;
    logic        note_strobe;
    logic        retrig;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int retrig_cnt = 0;

    logic [31:0] exp_freq [8];

    key_note_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .FREQ_WIDTH     (32),
        .FREQ_FRAC_BITS (16)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_n      (key_n),
        .gate       (gate),
        .freq       (freq),
        .note_idx   (note_idx),
        .note_strobe(note_strobe),
        .retrig     (retrig)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (note_strobe === 1'b1) strobe_cnt++;
        if (retrig === 1'b1) retrig_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        strobe_cnt = 0;
        retrig_cnt = 0;
    endtask

    initial begin
        exp_freq[0] = 32'h01B8_0000;
        exp_freq[1] = 32'h01EE_0000;
        exp_freq[2] = 32'h020B_0000;
        exp_freq[3] = 32'h024B_0000;
        exp_freq[4] = 32'h0293_0000;
        exp_freq[5] = 32'h02BA_0000;
        exp_freq[6] = 32'h0310_0000;
        exp_freq[7] = 32'h0370_0000;

        // Reset values
        reset = 1'b1;
        key_n = 2'b11;
        tick(4);
        check("rst_gate", {63'd0, gate}, 64'd0);
        check("rst_idx", {61'd0, note_idx}, 64'd0);
        check("rst_freq", {32'd0, freq}, 64'h01B8_0000);
        check("rst_strobe", {63'd0, note_strobe}, 64'd0);
        check("rst_retrig", {63'd0, retrig}, 64'd0);

        reset = 1'b0;
        clear_pulses();
        tick(100);
        check("idle_gate", {63'd0, gate}, 64'd0);
        check("idle_idx", {61'd0, note_idx}, 64'd0);
        check("idle_freq", {32'd0, freq}, 64'h01B8_0000);
        check("idle_strobes", 64'(strobe_cnt), 64'd0);
        check("idle_retrigs", 64'(retrig_cnt), 64'd0);

        // Gate latency: 18 cycles on press and on release
        key_n[0] = 1'b0;
        tick(17);
        check("gate_rise_early", {63'd0, gate}, 64'd0);
        tick(1);
        check("gate_rise", {63'd0, gate}, 64'd1);
        key_n[0] = 1'b1;
        tick(17);
        check("gate_fall_early", {63'd0, gate}, 64'd1);
        tick(1);
        check("gate_fall", {63'd0, gate}, 64'd0);
        tick(20);
        check("gate_no_strobe", 64'(strobe_cnt), 64'd0);

        // 10-cycle glitch on key 1 is ignored
        key_n[1] = 1'b0;
        tick(10);
        key_n[1] = 1'b1;
        tick(40);
        check("glitch_idx", {61'd0, note_idx}, 64'd0);
        check("glitch_strobes", 64'(strobe_cnt), 64'd0);

        // Eight press/release pairs walk the table and wrap
        for (int i = 0; i < 8; i++) begin
            key_n[1] = 1'b0;
            tick(40);
            check($sformatf("walk_idx_%0d", i), {61'd0, note_idx}, 64'((i + 1) % 8));
            check($sformatf("walk_freq_%0d", i), {32'd0, freq}, {32'd0, exp_freq[(i + 1) % 8]});
            key_n[1] = 1'b1;
            tick(40);
        end
        check("walk_end_freq", {32'd0, freq}, 64'h01B8_0000);
        check("walk_strobes", 64'(strobe_cnt), 64'd8);
        check("walk_retrigs", 64'(retrig_cnt), 64'd0);

        // Note advance with gate held: strobe and retrig one cycle after the index
        key_n[0] = 1'b0;
        tick(40);
        check("held_gate", {63'd0, gate}, 64'd1);
        clear_pulses();
        key_n[1] = 1'b0;
        tick(17);
        check("adv_idx_early", {61'd0, note_idx}, 64'd0);
        tick(1);
        check("adv_idx", {61'd0, note_idx}, 64'd1);
        check("adv_freq_old", {32'd0, freq}, 64'h01B8_0000);
        check("adv_strobe_early", {63'd0, note_strobe}, 64'd0);
        tick(1);
        check("adv_freq", {32'd0, freq}, 64'h01EE_0000);
        check("adv_strobe", {63'd0, note_strobe}, 64'd1);
        check("adv_retrig", {63'd0, retrig}, 64'd1);
        tick(1);
        check("adv_strobe_end", {63'd0, note_strobe}, 64'd0);
        check("adv_retrig_end", {63'd0, retrig}, 64'd0);
        tick(100);
        check("hold_no_repeat", {61'd0, note_idx}, 64'd1);
        key_n[1] = 1'b1;
        tick(40);
        check("release_no_effect", {61'd0, note_idx}, 64'd1);
        check("adv_strobe_count", 64'(strobe_cnt), 64'd1);
        check("adv_retrig_count", 64'(retrig_cnt), 64'd1);
        key_n[0] = 1'b1;
        tick(40);
        check("gate_off", {63'd0, gate}, 64'd0);

        // Both keys on the same cycle
        clear_pulses();
        key_n = 2'b00;
        tick(17);
        check("both_gate_early", {63'd0, gate}, 64'd0);
        check("both_idx_early", {61'd0, note_idx}, 64'd1);
        tick(1);
        check("both_gate", {63'd0, gate}, 64'd1);
        check("both_idx", {61'd0, note_idx}, 64'd2);
        tick(1);
        check("both_strobe", {63'd0, note_strobe}, 64'd1);
        check("both_retrig", {63'd0, retrig}, 64'd1);
        check("both_freq", {32'd0, freq}, 64'h020B_0000);
        key_n = 2'b11;
        tick(40);
        check("both_released_gate", {63'd0, gate}, 64'd0);

        // Reset 5 cycles into a key-1 debounce discards it
        key_n[1] = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(3);
        check("mid_rst_idx", {61'd0, note_idx}, 64'd0);
        check("mid_rst_freq", {32'd0, freq}, 64'h01B8_0000);
        key_n[1] = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_pulses();
        tick(60);
        check("post_rst_idx", {61'd0, note_idx}, 64'd0);
        check("post_rst_strobes", 64'(strobe_cnt), 64'd0);

        // Key held through reset is taken as a fresh press 18 cycles after release of reset
        key_n[1] = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        clear_pulses();
        tick(17);
        check("held_rst_idx_early", {61'd0, note_idx}, 64'd0);
        tick(1);
        check("held_rst_idx", {61'd0, note_idx}, 64'd1);
        tick(1);
        check("held_rst_freq", {32'd0, freq}, 64'h01EE_0000);
        check("held_rst_retrig", {63'd0, retrig}, 64'd0);
        key_n[1] = 1'b1;
        tick(40);
        check("held_rst_strobes", 64'(strobe_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
